// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and stream framing constants.
// No ports; imported by imem_loader and imem_word_packer.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        WORD,
        CHK,
        FIN,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // Running XOR used for the optional image checksum.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Byte-to-word assembler: shifts stream bytes MSB first and flags the 4th byte.
// Ports: clock/reset, shift_en (byte accepted), byte_in; word is the 32-bit
// big-endian word including the current byte, word_ready pulses with the 4th byte.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [23:0] sreg;
    logic [1:0]  idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            idx  <= '0;
        end else if (shift_en) begin
            sreg <= {sreg[15:0], byte_in};
            idx  <= idx + 2'd1;   // wraps to 0 after the last byte of a word
        end
    end

    // The completed word is presented combinationally alongside its final
    // byte so the FSM can register it on the same accepting edge.
    assign word       = {sreg, byte_in};
    assign word_ready = shift_en && (idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a count-prefixed byte stream, writes
// 32-bit big-endian words from address 0 and holds the core in reset until done.
// Ports: clock, reset (async high), start, in_valid/in_data/in_ready byte
// stream, mem_we/mem_addr/mem_wdata write port, core_reset, done, error.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam logic [31:0] CAP = 32'd1 << ADDR_W;

    state_t          state;
    logic [7:0]      cnt_hi;
    logic [ADDR_W:0] n_words;
    logic [ADDR_W:0] word_cnt;   // one bit wider so a full-capacity image never wraps
    logic            accept;
    logic [15:0]     n_word;
    logic            oversize;
    logic            last_word;
    logic [31:0]     word;
    logic            word_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      chk_acc;
`endif

    assign accept    = in_valid && in_ready;
    assign n_word    = {cnt_hi, in_data};
    assign oversize  = {16'd0, n_word} > CAP;
    assign last_word = (word_cnt == n_words - 1'b1);

    imem_word_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .shift_en   (accept && (state == WORD)),
        .byte_in    (in_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= HDR_HI;
            cnt_hi     <= '0;
            n_words    <= '0;
            word_cnt   <= '0;
            in_ready   <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc    <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                HDR_HI: begin
                    if (accept) begin
                        cnt_hi <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_acc <= in_data;
`endif
                        state  <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_acc <= chk_fold(chk_acc, in_data);
`endif
                        word_cnt <= '0;
                        n_words  <= n_word[ADDR_W:0];
                        if (oversize) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else if (n_word == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state    <= CHK;
`else
                            state    <= FIN;
                            in_ready <= 1'b0;
`endif
                        end else begin
                            state <= WORD;
                        end
                    end
                end
                WORD: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_acc <= chk_fold(chk_acc, in_data);
`endif
                        if (word_ready) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_cnt[ADDR_W-1:0];
                            mem_wdata <= word;
                            word_cnt  <= word_cnt + 1'b1;
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state    <= CHK;
`else
                                state    <= FIN;
                                in_ready <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == chk_acc) begin
                            state <= FIN;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                // FIN gives the last memory write a full cycle to commit
                // before the DONE-state outputs release the core.
                FIN: begin
                    state <= DONE;
                end
                DONE: begin
                    if (start) begin
                        state      <= HDR_HI;
                        in_ready   <= 1'b1;
                        done       <= 1'b0;
                        core_reset <= 1'b1;
                    end else begin
                        done       <= 1'b1;
                        core_reset <= 1'b0;
                    end
                end
                ERR: begin
                    if (start) begin
                        state    <= HDR_HI;
                        in_ready <= 1'b1;
                        error    <= 1'b0;
                    end
                end
                default: begin
                    state    <= HDR_HI;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=4) with a write scoreboard.
// Expected writes are queued as images are sent and popped on each mem_we.
// Checksum scenarios run only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_reset;
    logic          done;
    logic          error;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   stall_mode = 1'b0;
    wr_t  exp_q[$];
    logic [31:0] img[$];

    imem_loader #(.ADDR_W(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    // Scoreboard: every write strobe must match the oldest queued write.
    always @(negedge clock) begin
        if (!reset && mem_we) begin
            wr_t e;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL unexpected_write: observed addr=%0d data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                assert (mem_addr === e.addr && mem_wdata === e.data) else begin
                    n_fail++;
                    $error("FAIL write: observed addr=%0d data=%h, required addr=%0d data=%h",
                           mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   32'd1);
        check({tag, "_mem_we"},     32'(mem_we),     32'd0);
        check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
        check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
    endtask

    // Called and returns at posedge+1; drives a byte until it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        if (stall_mode && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(posedge clock); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 32) begin
            @(posedge clock); #1;
            waited++;
        end
        n_tests++;
        assert (waited < 32) else begin
            n_fail++;
            $error("FAIL in_ready_timeout: observed in_ready=%0b after %0d cycles, required 1", in_ready, waited);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_image(input logic [15:0] n, input bit corrupt);
        logic [7:0] c;
        logic [31:0] w;
        c = n[15:8] ^ n[7:0];
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        for (int k = 0; k < int'(n); k++) begin
            w = img[k];
            exp_q.push_back('{addr: AW'(k), data: w});
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31 - 8*b -: 8]);
                c = c ^ w[31 - 8*b -: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(corrupt ? (c ^ 8'h01) : c);
`else
        if (corrupt) c = 8'h00;
`endif
    endtask

    task automatic expect_done(input string tag);
        @(posedge clock); #1;
        check({tag, "_fin_done"},       32'(done),       32'd0);
        check({tag, "_fin_core_reset"}, 32'(core_reset), 32'd1);
        @(posedge clock); #1;
        check({tag, "_done"},       32'(done),       32'd1);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd0);
        check({tag, "_in_ready"},   32'(in_ready),   32'd0);
        check({tag, "_pending"},    32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
        check({tag, "_in_ready"},   32'(in_ready),   32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        check_reset_values("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Basic two-word load.
        img = '{32'h20080005, 32'h20090007};
        send_image(16'd2, 1'b0);
        expect_done("basic");
        check("basic_last_addr", 32'(mem_addr), 32'd1);
        do_start("restart1");

        // Same image with random input stalls.
        stall_mode = 1'b1;
        send_image(16'd2, 1'b0);
        stall_mode = 1'b0;
        expect_done("stall");
        do_start("restart2");

        // Zero-length image: no writes at all.
        img = {};
        send_image(16'd0, 1'b0);
        expect_done("zero");
        do_start("restart3");

        // Oversize count (17 > 16 words).
        send_byte(8'h00);
        send_byte(8'h11);
        check("oversize_error",      32'(error),      32'd1);
        check("oversize_in_ready",   32'(in_ready),   32'd0);
        check("oversize_core_reset", 32'(core_reset), 32'd1);
        check("oversize_done",       32'(done),       32'd0);
        repeat (3) @(posedge clock);
        #1;
        check("oversize_hold_error", 32'(error), 32'd1);
        do_start("restart_err");

        // Full capacity: 16 words, last at address 15, no wrap.
        img = {};
        for (int k = 0; k < 16; k++) img.push_back($urandom());
        send_image(16'd16, 1'b0);
        expect_done("full");
        check("full_last_addr", 32'(mem_addr), 32'd15);
        repeat (5) @(posedge clock);
        #1;
        check("full_idle_done", 32'(done), 32'd1);
        do_start("restart4");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: words still written, then ERR.
        img = '{32'hDEADBEEF};
        send_image(16'd1, 1'b1);
        check("chk_bad_error",      32'(error),      32'd1);
        check("chk_bad_core_reset", 32'(core_reset), 32'd1);
        check("chk_bad_done",       32'(done),       32'd0);
        check("chk_bad_in_ready",   32'(in_ready),   32'd0);
        do_start("restart_chk");
        send_image(16'd1, 1'b0);
        expect_done("chk_good");
        do_start("restart5");
`endif

        // Reset in the middle of word 1.
        img = '{32'h11223344, 32'h55667788};
        send_byte(8'h00);
        send_byte(8'h02);
        exp_q.push_back('{addr: AW'(0), data: 32'h11223344});
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        reset = 1'b1;
        #1;
        check_reset_values("midreset");
        check("midreset_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        img = '{32'hCAFEF00D};
        send_image(16'd1, 1'b0);
        expect_done("reload");
        check("reload_wdata", mem_wdata, 32'hCAFEF00D);

        repeat (3) @(posedge clock);
        #1;
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
